multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle RV32I core.
- Sequences one shared memory port, the instruction register, the register file, the ALU and the PC through fetch/decode/execute/memory/writeback phases, driven by the opcode of the latched instruction.
- Sits beside the immediate generator and shares its opcode map; it also owns a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 133 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core plus the retired-instruction counter.
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to park unrecognised opcodes in a sticky TRAP state.
module multicycle_ctrl #(
    parameter logic [31:0] RESET_COUNT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] instructions,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_src_imm,
    output logic [1:0]  wb_sel,
    output logic        busy,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t     state, state_nx;
    logic       retire;
    logic [6:0] opc;
    logic [4:0] rd;
    logic       is_load, is_store, is_branch, is_opimm, is_lui, is_jal, is_jalr, is_wb_op;
    logic       unused_bits;

    assign opc         = instructions[6:0];
    assign rd          = instructions[11:7];
    assign unused_bits = ^instructions[31:12];

    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_opimm  = (opc == OPC_OPIMM);
    assign is_lui    = (opc == OPC_LUI);
    assign is_jal    = (opc == OPC_JAL);
    assign is_jalr   = (opc == OPC_JALR);
    // Opcodes that finish in WB straight from EXEC (loads reach WB via MEM).
    assign is_wb_op  = (opc == OPC_OP) | is_opimm | is_lui | is_jal | is_jalr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        case (state)
            S_IDLE:   if (run) state_nx = S_FETCH;
            S_FETCH:  if (mem_ready) state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                if (is_load || is_store) state_nx = S_MEM;
                else if (is_wb_op)       state_nx = S_WB;
                else if (is_branch)      retire   = 1'b1;
                else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    state_nx = S_TRAP;
`else
                    retire = 1'b1;
`endif
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_store) retire   = 1'b1;
                    else          state_nx = S_WB;
                end
            end
            S_WB: retire = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: state_nx = S_TRAP;
`endif
            default: state_nx = S_IDLE;
        endcase
        // run is only looked at here and in IDLE, so a mid-instruction drop still completes it.
        if (retire) state_nx = run ? S_FETCH : S_IDLE;
    end

    always_comb begin
        mem_req     = (state == S_FETCH) || (state == S_MEM);
        mem_we      = (state == S_MEM) && is_store;
        ir_we       = (state == S_FETCH) && mem_ready;
        reg_we      = (state == S_WB) && (rd != 5'd0);
        pc_we       = retire;
        pc_sel      = 2'd0;
        wb_sel      = 2'd0;
        alu_src_imm = ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) &&
                      (is_opimm || is_load || is_store || is_jalr);
        busy        = (state != S_IDLE);
        if (state == S_EXEC && is_branch && branch_taken) pc_sel = 2'd1;
        if (state == S_WB) begin
            if (is_jal)       pc_sel = 2'd1;
            else if (is_jalr) pc_sel = 2'd2;
            if (is_load)                wb_sel = 2'd1;
            else if (is_jal || is_jalr) wb_sel = 2'd2;
            else if (is_lui)            wb_sel = 2'd3;
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal = (state == S_TRAP);
`else
        illegal = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instret <= RESET_COUNT;
        else if (retire) instret <= instret + 32'd1;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl: a memory responder issues instructions and
// pushes per-instruction expectations; a monitor checks each retire against them.
module tb_multicycle_ctrl;
    localparam logic [31:0] RC = 32'hFFFF_FFFF;
    localparam int C_OP = 0, C_OPI = 1, C_LUI = 2, C_JAL = 3, C_JALR = 4,
                   C_LD = 5, C_ST = 6, C_BR = 7, C_ILL = 8;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam int N_RAND = 8;
`else
    localparam int N_RAND = 9;
`endif

    logic        clk = 1'b0, rst_n, run, mem_ready, branch_taken;
    logic [31:0] instructions;
    logic        mem_req, mem_we, ir_we, reg_we, pc_we, alu_src_imm, busy, illegal;
    logic [1:0]  pc_sel, wb_sel;
    logic [31:0] instret;

    multicycle_ctrl #(.RESET_COUNT(RC)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instructions(instructions),
        .mem_ready(mem_ready), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_we(mem_we), .ir_we(ir_we), .reg_we(reg_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .alu_src_imm(alu_src_imm), .wb_sel(wb_sel),
        .busy(busy), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cls;
        int          lat;
        logic [1:0]  pc_sel;
        logic        reg_we;
        logic        chk_wb;
        logic [1:0]  wb_sel;
        logic        alu_imm;
        logic        store;
        logic [31:0] instret;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0, errors = 0;
    int          tgt = -1, wcnt = 0, pushed = 0;
    int          force_cls = -1, force_mw = -1;
    bit          rand_run = 0, no_push = 0;
    logic [31:0] nxt_instret = RC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] opc(input int cls);
        case (cls)
            C_OP:    return 7'b0110011;
            C_OPI:   return 7'b0010011;
            C_LUI:   return 7'b0110111;
            C_JAL:   return 7'b1101111;
            C_JALR:  return 7'b1100111;
            C_LD:    return 7'b0000011;
            C_ST:    return 7'b0100011;
            C_BR:    return 7'b1100011;
            default: return 7'h7F;
        endcase
    endfunction

    // What the retire cycle of one instruction should look like, from the opcode's role.
    function automatic exp_t model(input int cls, input logic [4:0] rd, input logic bt,
                                   input int fw, input int mw, input logic [31:0] pre);
        exp_t e;
        logic wr;
        wr = (cls == C_OP) || (cls == C_OPI) || (cls == C_LUI) || (cls == C_JAL) ||
             (cls == C_JALR) || (cls == C_LD);
        e.cls     = cls;
        e.lat     = fw + ((cls == C_LD || cls == C_ST) ? mw : 0) +
                    ((cls == C_LD) ? 5 : (cls == C_BR || cls == C_ILL) ? 3 : 4);
        e.pc_sel  = (cls == C_BR) ? (bt ? 2'd1 : 2'd0) : (cls == C_JAL) ? 2'd1 :
                    (cls == C_JALR) ? 2'd2 : 2'd0;
        e.reg_we  = wr && (rd != 5'd0);
        e.chk_wb  = wr;
        e.wb_sel  = (cls == C_LD) ? 2'd1 : (cls == C_JAL || cls == C_JALR) ? 2'd2 :
                    (cls == C_LUI) ? 2'd3 : 2'd0;
        e.alu_imm = (cls == C_OPI) || (cls == C_LD) || (cls == C_ST) || (cls == C_JALR);
        e.store   = (cls == C_ST);
        e.instret = pre;
        return e;
    endfunction

    task automatic issue(input int fw);
        int          cls, mw;
        logic [4:0]  rd;
        logic        bt;
        logic [31:0] w;
        cls = (force_cls >= 0) ? force_cls : $urandom_range(0, N_RAND - 1);
        rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bt  = 1'($urandom_range(0, 1));
        mw  = (force_mw >= 0) ? force_mw : $urandom_range(0, 3);
        w   = ($urandom() & 32'hFFFF_F000) | {20'd0, rd, opc(cls)};
        instructions = w;
        branch_taken = bt;
        tgt = (cls == C_LD || cls == C_ST) ? mw : -1;
        if (!no_push) begin
            sbq.push_back(model(cls, rd, bt, fw, mw, nxt_instret));
            nxt_instret++;
            pushed++;
        end
    endtask

    // Memory responder: inserts wait cycles, supplies the fetched word.
    initial begin
        int fw;
        mem_ready = 0; run = 0; branch_taken = 0; instructions = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wcnt = 0; tgt = -1; mem_ready = 0;
            end else begin
                if (rand_run) run = ($urandom_range(0, 3) != 0);
                if (mem_req) begin
                    if (tgt < 0) tgt = $urandom_range(0, 3);
                    if (wcnt >= tgt) begin
                        mem_ready = 1; fw = wcnt; wcnt = 0; tgt = -1;
                        #1;
                        if (ir_we) issue(fw);
                    end else begin
                        mem_ready = 0; wcnt++;
                    end
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Monitor: every retire pops one expectation.
    initial begin
        int   cnt = 0;
        bit   chk_busy = 0;
        logic exp_busy = 0;
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                cnt = 0; chk_busy = 0;
            end else begin
                if (chk_busy) begin
                    chk("busy_after_retire", busy, exp_busy);
                    chk_busy = 0;
                end
                if (busy) cnt++; else cnt = 0;
                chk("mem_we_without_req", mem_we & ~mem_req, 0);
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
                chk("illegal_tied", illegal, 0);
`endif
                if (pc_we) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("latency", cnt, e.lat);
                        chk("pc_sel", pc_sel, e.pc_sel);
                        chk("reg_we", reg_we, e.reg_we);
                        if (e.chk_wb) chk("wb_sel", wb_sel, e.wb_sel);
                        chk("alu_src_imm", alu_src_imm, e.alu_imm);
                        chk("mem_we_retire", mem_we, e.store);
                        chk("mem_req_retire", mem_req, e.store);
                        chk("instret", instret, e.instret);
                    end
                    cnt = 0; chk_busy = 1; exp_busy = run;
                end else if (reg_we) begin
                    chk("reg_we_without_retire", reg_we, 0);
                end
            end
        end
    end

    initial begin
        bit ok;
        rst_n = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_instret", instret, RC);
        chk("rst_strobes", {mem_req, mem_we, ir_we, reg_we, pc_we}, 0);
        rst_n = 1;

        rand_run = 1;
        for (int i = 0; i < 20000 && pushed < 80; i++) @(negedge clk);
        chk("random_phase_timeout", (pushed >= 80), 1);
        rand_run = 0; run = 0;
        for (int i = 0; i < 300 && (busy || sbq.size() != 0); i++) @(negedge clk);
        #2;
        chk("drain_queue_empty", sbq.size(), 0);
        chk("drain_idle", busy, 0);

        // Reset during a long MEM wait of a load.
        no_push = 1; force_cls = C_LD; force_mw = 40; run = 1;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #3;
            ok = mem_req && (tgt >= 0) && (wcnt >= 5);
        end
        chk("mem_wait_reached", ok, 1);
        run = 0;
        rst_n = 0;
        #1;
        chk("midrst_strobes", {mem_req, mem_we, ir_we, reg_we, pc_we}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_instret", instret, RC);
        @(negedge clk);
        rst_n = 1; force_cls = -1; force_mw = -1; nxt_instret = RC;
        repeat (2) @(negedge clk);
        #2;
        chk("post_rst_idle", busy, 0);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        force_cls = C_ILL; run = 1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); #3;
            ok = illegal;
        end
        chk("trap_reached", ok, 1);
        run = 0;
        repeat (5) @(negedge clk);
        #2;
        chk("trap_illegal", illegal, 1);
        chk("trap_busy", busy, 1);
        chk("trap_instret", instret, RC);
        chk("trap_strobes", {mem_req, mem_we, ir_we, reg_we, pc_we}, 0);
        rst_n = 0;
        #1;
        chk("trap_rst_illegal", illegal, 0);
        chk("trap_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1; force_cls = -1;
        repeat (2) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
